// File: rtl/spi_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_ctrl_if
// Brief    : SPI byte-slave handshake and display-driver bundle for spi_cmd_ctrl
// Revision : 1.0 - initial release
// ============================================================================
interface spi_cmd_ctrl_if;
    logic       spi_cs;
    logic       rx_ready;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [1:0] colon;
    logic       frame_busy;

    modport master (
        output spi_cs, rx_ready, rx_byte,
        input  tx_byte, tx_load, digit0, digit1, digit2, digit3, colon, frame_busy
    );

    modport slave (
        input  spi_cs, rx_ready, rx_byte,
        output tx_byte, tx_load, digit0, digit1, digit2, digit3, colon, frame_busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_ctrl
// Brief    : Two-byte SPI frame sequencer driving the 7-segment display registers.
//            Optional burst writes when SPI_CMD_AUTOINC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_ctrl #(
    parameter logic [7:0] DEV_ID    = 8'hA5,
    parameter logic [7:0] ACK_BYTE  = 8'h5A,
    parameter logic [1:0] COLON_RST = 2'b11
) (
    input  wire logic     clk,
    input  wire logic     reset,
    spi_cmd_ctrl_if.slave bus
);

`ifdef SPI_CMD_AUTOINC_EN
    localparam bit c_AUTOINC = 1'b1;
`else
    localparam bit c_AUTOINC = 1'b0;
`endif

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CMD  = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [1:0] c_OP_NOP   = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_READ  = 2'b10;

    // Bit 0 = s1, bit 1 = s2, bit 2 = edge-detect flop s3
    logic [2:0] r_cs_sync;
    logic [2:0] r_rdy_sync;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [1:0] r_op;
    logic [2:0] r_addr;
    logic       r_wrote;
    logic [7:0] r_tx_byte;
    logic       r_tx_load;
    logic [3:0] r_digit [4];
    logic [1:0] r_colon;
    logic [7:0] r_scratch;
    logic [7:0] r_err_cnt;

    logic       w_rx_evt;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic [1:0] w_cmd_op;
    logic [2:0] w_cmd_addr;
    logic [7:0] w_rd_data;
    logic       w_load;
    logic [7:0] w_load_val;
    logic       w_latch_cmd;
    logic       w_wr_en;
    logic       w_addr_inc;
    logic       w_err_inc;
    logic       w_frame_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_sync  <= 3'b111;
            r_rdy_sync <= 3'b000;
        end else begin
            r_cs_sync  <= {r_cs_sync[1:0], bus.spi_cs};
            r_rdy_sync <= {r_rdy_sync[1:0], bus.rx_ready};
        end
    end

    assign w_rx_evt   = r_rdy_sync[1] & ~r_rdy_sync[2];
    assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_cmd_op   = bus.rx_byte[7:6];
    assign w_cmd_addr = bus.rx_byte[2:0];

    // Read data is selected from the command byte itself so it can be loaded on the same edge
    always_comb begin
        w_rd_data = 8'h00;
        case (w_cmd_addr)
            3'd0:    w_rd_data = {4'h0, r_digit[0]};
            3'd1:    w_rd_data = {4'h0, r_digit[1]};
            3'd2:    w_rd_data = {4'h0, r_digit[2]};
            3'd3:    w_rd_data = {4'h0, r_digit[3]};
            3'd4:    w_rd_data = {6'h00, r_colon};
            3'd5:    w_rd_data = r_scratch;
            3'd6:    w_rd_data = DEV_ID;
            default: w_rd_data = r_err_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_cs_fall) w_state_nxt = c_ST_CMD;
            c_ST_CMD: begin
                if (w_rx_evt) begin
                    if (w_cmd_op == c_OP_READ || w_cmd_op == c_OP_WRITE) w_state_nxt = c_ST_DATA;
                    else                                               w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DATA: begin
                if (w_rx_evt && !(c_AUTOINC && r_op == c_OP_WRITE)) w_state_nxt = c_ST_DONE;
            end
            default: w_state_nxt = r_state;
        endcase
        // Chip-select release overrides everything, after any same-edge byte was handled
        if (w_cs_rise) w_state_nxt = c_ST_IDLE;
    end

    always_comb begin
        w_load       = 1'b0;
        w_load_val   = 8'h00;
        w_latch_cmd  = 1'b0;
        w_wr_en      = 1'b0;
        w_addr_inc   = 1'b0;
        w_err_inc    = 1'b0;
        w_frame_busy = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_IDLE: begin
                if (w_cs_fall) begin
                    w_load     = 1'b1;
                    w_load_val = ACK_BYTE;
                end
            end
            c_ST_CMD: begin
                if (w_rx_evt) begin
                    w_latch_cmd = 1'b1;
                    case (w_cmd_op)
                        c_OP_READ: begin
                            w_load     = 1'b1;
                            w_load_val = w_rd_data;
                        end
                        c_OP_WRITE, c_OP_NOP: w_load = 1'b1;
                        default:              w_err_inc = 1'b1;
                    endcase
                end
            end
            c_ST_DATA: begin
                if (w_rx_evt) begin
                    w_wr_en    = (r_op == c_OP_WRITE);
                    w_addr_inc = c_AUTOINC && (r_op == c_OP_WRITE);
                end else if (w_cs_rise && !(c_AUTOINC && r_wrote)) begin
                    w_err_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_byte <= 8'h00;
            r_tx_load <= 1'b0;
            r_op      <= 2'b00;
            r_addr    <= 3'd0;
            r_wrote   <= 1'b0;
            for (int i = 0; i < 4; i++) r_digit[i] <= 4'h0;
            r_colon   <= COLON_RST;
            r_scratch <= 8'h00;
            r_err_cnt <= 8'h00;
        end else begin
            r_tx_load <= w_load;
            if (w_load) r_tx_byte <= w_load_val;

            if (w_latch_cmd) begin
                r_op   <= w_cmd_op;
                r_addr <= w_cmd_addr;
            end else if (w_addr_inc) begin
                r_addr <= r_addr + 3'd1;
            end

            if (w_wr_en)                  r_wrote <= 1'b1;
            else if (r_state == c_ST_IDLE) r_wrote <= 1'b0;

            if (w_wr_en) begin
                case (r_addr)
                    3'd0, 3'd1, 3'd2, 3'd3: r_digit[r_addr[1:0]] <= bus.rx_byte[3:0];
                    3'd4:    r_colon   <= bus.rx_byte[1:0];
                    3'd5:    r_scratch <= bus.rx_byte;
                    default: ;
                endcase
            end

            // Clearing via a write to address 7 takes priority over a same-edge increment
            if (w_wr_en && r_addr == 3'd7)          r_err_cnt <= 8'h00;
            else if (w_err_inc && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.tx_byte    = r_tx_byte;
    assign bus.tx_load    = r_tx_load;
    assign bus.digit0     = r_digit[0];
    assign bus.digit1     = r_digit[1];
    assign bus.digit2     = r_digit[2];
    assign bus.digit3     = r_digit[3];
    assign bus.colon      = r_colon;
    assign bus.frame_busy = w_frame_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cmd_ctrl
// Brief    : Frame-level randomized bench for spi_cmd_ctrl with a register-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_ctrl;

`ifdef SPI_CMD_AUTOINC_EN
    localparam bit c_AUTOINC = 1'b1;
`else
    localparam bit c_AUTOINC = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    spi_cmd_ctrl_if bus ();

    spi_cmd_ctrl #(
        .DEV_ID    (8'hA5),
        .ACK_BYTE  (8'h5A),
        .COLON_RST (2'b11)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0]  frm[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  exp_tx[$];
    logic [15:0] dig_snap[8];
    logic        prev_load = 1'b0;

    logic [3:0] m_digit[4];
    logic [1:0] m_colon;
    logic [7:0] m_scratch;
    logic [7:0] m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.tx_load === 1'b1) begin
            tx_q.push_back(bus.tx_byte);
            chk("tx_load_gap", {31'd0, prev_load}, 32'd0);
        end
        prev_load = bus.tx_load;
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
        m_colon   = 2'b11;
        m_scratch = 8'h00;
        m_err     = 8'h00;
    endtask

    task automatic m_err_inc();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    function automatic logic [7:0] m_read(input int a);
        if (a < 4)  return {4'h0, m_digit[a]};
        if (a == 4) return {6'h00, m_colon};
        if (a == 5) return m_scratch;
        if (a == 6) return 8'hA5;
        return m_err;
    endfunction

    task automatic m_write(input int a, input logic [7:0] v);
        if (a < 4)       m_digit[a] = v[3:0];
        else if (a == 4) m_colon = v[1:0];
        else if (a == 5) m_scratch = v;
        else if (a == 7) m_err = 8'h00;
    endtask

    // Frame semantics: ack byte, then a response to the command, then data handling
    task automatic model_frame();
        int op;
        int a;
        exp_tx.delete();
        exp_tx.push_back(8'h5A);
        if (frm.size() == 0) return;
        op = int'(frm[0] >> 6);
        a  = int'(frm[0] & 8'h07);
        if (op == 0) begin
            exp_tx.push_back(8'h00);
        end else if (op == 3) begin
            m_err_inc();
        end else if (op == 2) begin
            exp_tx.push_back(m_read(a));
            if (frm.size() == 1) m_err_inc();
        end else begin
            exp_tx.push_back(8'h00);
            if (frm.size() == 1) m_err_inc();
            else if (c_AUTOINC) begin
                for (int i = 1; i < frm.size(); i++) begin
                    m_write(a, frm[i]);
                    a = (a + 1) % 8;
                end
            end else m_write(a, frm[1]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            dig_snap[k] = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
        end
        bus.rx_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_d0"}, {28'd0, bus.digit0}, {28'd0, m_digit[0]});
        chk({tag, "_d1"}, {28'd0, bus.digit1}, {28'd0, m_digit[1]});
        chk({tag, "_d2"}, {28'd0, bus.digit2}, {28'd0, m_digit[2]});
        chk({tag, "_d3"}, {28'd0, bus.digit3}, {28'd0, m_digit[3]});
        chk({tag, "_colon"}, {30'd0, bus.colon}, {30'd0, m_colon});
    endtask

    task automatic run_frame(input string tag);
        tx_q.delete();
        bus.spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        chk({tag, "_busy"}, {31'd0, bus.frame_busy}, 32'd1);
        foreach (frm[i]) send_byte(frm[i]);
        repeat (2) @(negedge clk);
        bus.spi_cs = 1'b1;
        repeat (5) @(negedge clk);
        model_frame();
        chk({tag, "_idle"}, {31'd0, bus.frame_busy}, 32'd0);
        chk({tag, "_nload"}, tx_q.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
            chk({tag, "_tx"}, {24'd0, tx_q[i]}, {24'd0, exp_tx[i]});
        chk({tag, "_txhold"}, {24'd0, bus.tx_byte}, {24'd0, exp_tx[exp_tx.size()-1]});
        check_regs(tag);
    endtask

    initial begin
        reset        = 1'b1;
        bus.spi_cs   = 1'b1;
        bus.rx_ready = 1'b0;
        bus.rx_byte  = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_txbyte", {24'd0, bus.tx_byte}, 32'd0);
        chk("rst_txload", {31'd0, bus.tx_load}, 32'd0);
        chk("rst_busy", {31'd0, bus.frame_busy}, 32'd0);
        check_regs("rst");

        frm.delete();
        run_frame("cs_only");

        frm = '{8'h41, 8'h07};
        run_frame("wr_d1");
        chk("wr_d1_edge2", {28'd0, dig_snap[1][7:4]}, 32'd0);
        chk("wr_d1_edge3", {28'd0, dig_snap[2][7:4]}, 32'd7);

        frm = '{8'h86, 8'h3C};
        run_frame("rd_id");
        frm = '{8'hC0};
        run_frame("rsv");
        frm = '{8'h43};
        run_frame("abort");
        frm = '{8'h87, 8'h00};
        run_frame("rd_err2");
        frm = '{8'h47, 8'h99};
        run_frame("clr_err");
        frm = '{8'h87, 8'h00};
        run_frame("rd_err0");

        for (int n = 0; n < 300; n++) begin
            frm = '{8'hC0 | 8'($urandom_range(0, 63))};
            model_frame();
            bus.spi_cs = 1'b0;
            repeat (4) @(negedge clk);
            send_byte(frm[0]);
            bus.spi_cs = 1'b1;
            repeat (5) @(negedge clk);
        end
        frm = '{8'h87, 8'h00};
        run_frame("rd_sat");

        frm = '{8'h40, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_frame("burst");
        frm = '{8'h46, 8'h12};
        run_frame("wr_ro");
        frm = '{8'h86, 8'h00};
        run_frame("rd_id2");

        for (int n = 0; n < 120; n++) begin
            int nb;
            frm.delete();
            nb = $urandom_range(0, 4);
            for (int i = 0; i < nb; i++) frm.push_back(8'($urandom));
            if (nb > 0 && $urandom_range(0, 2) == 0) frm[0] = 8'h80 | (frm[0] & 8'h07);
            run_frame("rnd");
        end

        // Reset in the middle of a write frame
        bus.spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h42);
        reset      = 1'b1;
        bus.spi_cs = 1'b1;
        @(negedge clk);
        model_reset();
        chk("mid_rst_busy", {31'd0, bus.frame_busy}, 32'd0);
        chk("mid_rst_tx", {24'd0, bus.tx_byte}, 32'd0);
        check_regs("mid_rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        frm = '{8'h87, 8'h00};
        run_frame("rd_err_rst");
        frm = '{8'h85, 8'h00};
        run_frame("rd_scr_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
